// File: rtl/idex_skid_stage.sv
// ID/EX pipeline stage: valid/ready handshake, 2-entry skid buffer,
// flush-to-bubble and saturating execute-stall counter.
module idex_skid_stage #(
  parameter int DATA_W = 108,
  parameter int CTRL_W = 13,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t st, nst;

  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic accept;
  logic issue;
  logic ld_main_in;
  logic ld_main_skid;
  logic ld_skid;

  // Both valid bits fall straight out of the state register, so in_ready
  // never depends combinationally on out_ready.
  assign out_valid = (st != EMPTY);
  assign in_ready  = (st != FULL);
  assign occupancy = st;

  assign accept = in_valid & in_ready;
  assign issue  = out_valid & out_ready;

  // Invalid cycles present a NOP control word downstream.
  assign out_ctrl = out_valid ? main_ctrl : '0;
  assign out_data = main_data;

  always_comb begin
    nst          = st;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      nst = EMPTY;
    end else begin
      unique case (st)
        EMPTY: begin
          if (accept) begin
            nst        = ONE;
            ld_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && issue) begin
            ld_main_in = 1'b1;
          end else if (accept) begin
            nst     = FULL;
            ld_skid = 1'b1;
          end else if (issue) begin
            nst = EMPTY;
          end
        end
        FULL: begin
          if (issue) begin
            nst          = ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: nst = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      st <= EMPTY;
    end else begin
      st <= nst;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      main_ctrl <= '0;
      main_data <= '0;
    end else if (ld_main_in) begin
      main_ctrl <= in_ctrl;
      main_data <= in_data;
    end else if (ld_main_skid) begin
      main_ctrl <= skid_ctrl;
      main_data <= skid_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (ld_skid) begin
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end
  end

  // Counts through flushes; only CLR clears it.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_idex_skid_stage.sv
// Scoreboard bench for idex_skid_stage: directed phases then random
// traffic, with a CNT_W=4 twin for counter saturation.
module tb_idex_skid_stage;

  localparam int DW = 108;
  localparam int CW = 13;

  logic          CLK;
  logic          CLR;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_ready;

  logic          in_ready;
  logic          out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;

  logic          in_ready4;
  logic          out_valid4;
  logic [CW-1:0] out_ctrl4;
  logic [DW-1:0] out_data4;
  logic [1:0]    occupancy4;
  logic [3:0]    stall_cnt4;

  idex_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
    .CLK(CLK), .CLR(CLR),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  idex_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) dut4 (
    .CLK(CLK), .CLR(CLR),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_ctrl(out_ctrl4), .out_data(out_data4),
    .occupancy(occupancy4), .stall_cnt(stall_cnt4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } item_t;

  item_t       q[$];
  logic [15:0] m_stall;
  logic [3:0]  m_stall4;
  int          n_chk;
  int          n_pass;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all();
    logic [CW-1:0] ec;
    ec = (q.size() != 0) ? q[0].c : '0;
    chk("occupancy", 128'(occupancy), 128'(q.size()));
    chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
    chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
    chk("out_ctrl", 128'(out_ctrl), 128'(ec));
    if (q.size() != 0) chk("out_data", 128'(out_data), 128'(q[0].d));
    chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
    chk("stall_cnt4", 128'(stall_cnt4), 128'(m_stall4));
  endtask

  function automatic logic [DW-1:0] rdata();
    return {$urandom, $urandom, $urandom, 12'($urandom)};
  endfunction

  // Called at a negedge: drive, clock, update model, check.
  task automatic cyc(logic iv, logic [CW-1:0] ic, logic fl,
                     logic ordy, logic clr);
    logic  pv;
    logic  pr;
    item_t it;
    it.c      = ic;
    it.d      = rdata();
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = it.d;
    flush     = fl;
    out_ready = ordy;
    CLR       = clr;
    pv = (q.size() != 0);
    pr = (q.size() < 2);
    @(posedge CLK);
    if (clr) begin
      q.delete();
      m_stall  = '0;
      m_stall4 = '0;
    end else begin
      if (pv && !ordy) begin
        if (m_stall != 16'hFFFF) m_stall++;
        if (m_stall4 != 4'hF) m_stall4++;
      end
      if (fl) q.delete();
      else begin
        if (pv && ordy) void'(q.pop_front());
        if (iv && pr) q.push_back(it);
      end
    end
    @(negedge CLK);
    check_all();
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    m_stall = '0; m_stall4 = '0;
    in_valid = 0; in_ctrl = '0; in_data = '0;
    flush = 0; out_ready = 0; CLR = 1;
    @(negedge CLK);

    cyc(1, 13'h5, 0, 1, 1);
    chk("rst_data", 128'(out_data), 128'(0));

    // streaming
    for (int i = 1; i <= 8; i++) cyc(1, CW'(i), 0, 1, 0);
    cyc(0, '0, 0, 1, 0);
    chk("stream_stall", 128'(stall_cnt), 128'(0));

    // back-pressure
    cyc(1, 13'h11, 0, 0, 0);
    cyc(1, 13'h12, 0, 0, 0);
    cyc(1, 13'h13, 0, 0, 0);
    chk("bp_occ", 128'(occupancy), 128'(2));
    chk("bp_ctrl", 128'(out_ctrl), 128'(13'h11));
    for (int i = 0; i < 4; i++) cyc(1, 13'h13, 0, 1, 0);
    cyc(0, '0, 0, 1, 0);

    // flush in FULL
    cyc(1, 13'h21, 0, 0, 0);
    cyc(1, 13'h22, 0, 0, 0);
    cyc(1, 13'h1F, 1, 0, 0);
    chk("fl_occ", 128'(occupancy), 128'(0));
    chk("fl_ctrl", 128'(out_ctrl), 128'(0));
    for (int i = 0; i < 3; i++) cyc(0, '0, 0, 1, 0);

    // saturation of the 4-bit twin
    for (int i = 0; i < 20; i++) cyc(1, 13'h30, 0, 0, 0);
    chk("sat4", 128'(stall_cnt4), 128'(15));

    // reset mid-operation with stall_cnt=5
    cyc(1, '0, 0, 1, 1);
    for (int i = 0; i < 6; i++) cyc(1, CW'(13'h40 + i), 0, 0, 0);
    chk("pre_clr_stall", 128'(stall_cnt), 128'(5));
    cyc(1, 13'h4F, 0, 1, 1);
    chk("clr_data", 128'(out_data), 128'(0));
    chk("clr_stall", 128'(stall_cnt), 128'(0));
    chk("clr_ready", 128'(in_ready), 128'(1));

    // random traffic
    for (int i = 0; i < 10000; i++)
      cyc(($urandom_range(0, 9) < 7), CW'($urandom),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 9) < 6), 0);
    for (int i = 0; i < 3; i++) cyc(0, '0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/idex_skid_stage.md
Name: idex_skid_stage

Overview:
Parametrised ID/EX pipeline stage with a valid/ready handshake and a 2-entry skid buffer. It replaces the free-running decode-to-execute register, so the decode stage can be back-pressured by a stalled execute stage without losing or duplicating instructions. It inserts bubbles on flush (branch or exception) and counts execute-side stall cycles for performance monitoring.

Parameters:
DATA_W, 108, width of packed datapath payload (ports A/B/C 3x32 + shifter amount 12)
CTRL_W, 13, width of packed control word (shift, ALU op, size, enable, rw, load, S, rf, Rd tag)
CNT_W, 16, width of saturating stall counter

Ports:
CLK  input  1  clock, all state updates on rising edge
CLR  input  1  synchronous active-high reset
in_valid  input  1  decode presents an instruction
in_ready  output  1  stage can accept; registered, equals NOT skid_valid
in_ctrl  input  CTRL_W  control word from decode
in_data  input  DATA_W  payload from decode
flush  input  1  squash all held and incoming instructions this cycle
out_valid  output  1  instruction present for execute
out_ready  input  1  execute consumes this cycle
out_ctrl  output  CTRL_W  control word to execute; forced all-zero when out_valid=0
out_data  output  DATA_W  payload to execute; holds last value when invalid
occupancy  output  2  entries held (0,1,2)
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage: main register (drives out_*) and skid register, each with its own valid bit.
- Transfers: accept = in_valid & in_ready; issue = out_valid & out_ready.
- States, encoded as occupancy: EMPTY(0), ONE(1, main only), FULL(2, main+skid).
- EMPTY: accept -> main loads input -> ONE. Latency is 1 cycle, input to out_valid.
- ONE, accept & issue: main reloads from input, stays ONE. This gives full throughput of 1 instr/cycle.
- ONE, accept & !issue: input goes to skid -> FULL. in_ready drops next cycle.
- ONE, issue & !accept -> EMPTY.
- FULL: in_ready=0, so no accept. On issue, main loads from skid, skid clears -> ONE.
- Ordering is strictly FIFO. No instruction is dropped or duplicated except by flush.
- flush has priority over all transfers. Next cycle both valid bits are 0, occupancy=0, in_ready=1 and out_ctrl=0.
  - An input presented in the flush cycle is discarded.
  - An issue in the flush cycle is still a valid handshake for execute, since out_* were valid during that cycle.
- Bubble rule: out_ctrl is combinationally zero whenever out_valid=0. Downstream therefore sees a NOP (no writeback, no memory enable).
- out_data is not cleared on bubble, except by CLR.
- stall_cnt increments by 1 on any cycle with out_valid & !out_ready.
  - It saturates at 2^CNT_W-1 with no wrap.
  - It is not cleared by flush.
- CLR: every register resets, regardless of flush/in_valid/out_ready in the same cycle.
  - Reset values: main and skid valid=0, out_data=0, skid contents=0, stall_cnt=0, occupancy=0.
  - Resulting outputs: in_ready=1, out_valid=0, out_ctrl=0.
- CLR mid-operation, e.g. in FULL: contents are lost and the next cycle is EMPTY.
- No combinational path from out_ready to in_ready.

Test Plan:
- Streaming: CLR 1 cycle, then in_valid=1 with out_ready=1 for 8 cycles, in_ctrl=1..8. -> out_valid rises 1 cycle after first accept, out_ctrl 1..8 on consecutive cycles, in_ready stays 1, stall_cnt=0.
- Back-pressure: out_ready=0 and present ctrl 0x11, 0x12, 0x13. -> 0x11 in main, 0x12 in skid, occupancy=2, in_ready=0, and 0x13 holds at input. Then out_ready=1 -> outputs 0x11, 0x12, 0x13 in order, none lost; stall_cnt equals the number of stalled cycles.
- Flush in FULL: assert flush with in_valid=1 (ctrl 0x1F). -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1. 0x1F never appears on output.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles. -> stall_cnt reaches 15 and holds 15.
- Reset mid-operation: in FULL with stall_cnt=5, assert CLR together with flush=0, out_ready=1. -> next cycle all outputs at reset values (out_data=0, stall_cnt=0).
- Random: random in_valid/out_ready/flush for 10k cycles against a scoreboard FIFO. -> output order matches, with no duplicates and no drops except flushed entries.
